// File: rtl/mux_scan_pkg.sv
// Shared state enum, select-width helper and mask scan helper for the mux scan serializer.
// next_set_idx is only referenced when MUX_SCAN_MASK_EN is defined.
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Upper bound on frame length that next_set_idx can scan.
  localparam int MAX_N = 32;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set index at or above 'from', or -1 when no such bit exists.
  function automatic int next_set_idx(input logic [MAX_N-1:0] mask, input int from);
    int idx;
    idx = -1;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_scan_serializer_if.sv
// Frame-in / word-out handshake bundle for mux_scan_serializer.
// in_mask exists only when MUX_SCAN_MASK_EN is defined.
interface mux_scan_serializer_if
  import mux_scan_pkg::*;
#(
  parameter int N = 9,
  parameter int W = 1
);
  localparam int SEL_W = sel_w(N);

  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0]     in_mask;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_last;

  modport master (
    output in_valid,
    output in_data,
`ifdef MUX_SCAN_MASK_EN
    output in_mask,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef MUX_SCAN_MASK_EN
    input  in_mask,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    output out_last
  );

endinterface

// File: rtl/mux_if_bal_9_1.sv
// N:1 word select mux (9:1 by default), purely combinational.
// Selects at or above N read as zero, though the serializer never drives them.
module mux_if_bal_9_1
  import mux_scan_pkg::*;
#(
  parameter int N = 9,
  parameter int W = 1,
  localparam int SEL_W = sel_w(N)
) (
  input  logic [N*W-1:0]   data_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [W-1:0]     data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) data_o = data_i[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Latches an N-word frame and steps the mux select across it, one word per out beat, first word one cycle after accept.
// in_ready depends combinationally on out_ready during the last beat; MUX_SCAN_MASK_EN adds per-word skip mask.
module mux_scan_serializer
  import mux_scan_pkg::*;
#(
  parameter int N = 9,
  parameter int W = 1
) (
  input  logic                clk,
  input  logic                rst,
  mux_scan_serializer_if.slave bus
);
  localparam int SEL_W = sel_w(N);

  state_e           state_q, state_d;
  logic [N*W-1:0]   frame_q, frame_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     out_data;
  logic             in_ready;
  logic             beat;
  logic             accept;
  logic             last;

`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0] mask_q, mask_d;
  int           first_idx;
  int           next_idx;

  always_comb begin
    first_idx = next_set_idx(MAX_N'(bus.in_mask), 0);
    next_idx  = next_set_idx(MAX_N'(mask_q), int'(sel_q) + 1);
  end

  assign last = (state_q == SCAN) && (next_idx < 0);
`else
  assign last = (state_q == SCAN) && (sel_q == SEL_W'(N - 1));
`endif

  assign beat     = (state_q == SCAN) && bus.out_ready;
  assign in_ready = (state_q == IDLE) || (beat && last);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == SCAN);
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = last;
  assign bus.out_data  = out_data;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    sel_d   = sel_q;
`ifdef MUX_SCAN_MASK_EN
    mask_d  = mask_q;
`endif
    // A load on the last beat takes priority over returning to IDLE.
    if (accept) begin
      frame_d = bus.in_data;
`ifdef MUX_SCAN_MASK_EN
      mask_d  = bus.in_mask;
      if (first_idx >= 0) begin
        state_d = SCAN;
        sel_d   = SEL_W'(first_idx);
      end else begin
        state_d = IDLE;
      end
`else
      state_d = SCAN;
      sel_d   = '0;
`endif
    end else if (beat) begin
      if (last) begin
        state_d = IDLE;
      end else begin
`ifdef MUX_SCAN_MASK_EN
        sel_d = SEL_W'(next_idx);
`else
        sel_d = sel_q + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      sel_q   <= '0;
`ifdef MUX_SCAN_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      sel_q   <= sel_d;
`ifdef MUX_SCAN_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  mux_if_bal_9_1 #(
    .N (N),
    .W (W)
  ) u_mux (
    .data_i (frame_q),
    .sel_i  (sel_q),
    .data_o (out_data)
  );

endmodule

// File: doc/mux_scan_serializer.md
# mux_scan_serializer

Upstream sequencer for the codebase's 9:1 balanced if-mux. Accepts a parallel frame of N words of W bits through a valid/ready handshake, latches it, and steps the mux select through the frame, emitting one word per accepted output beat with a last flag. It is the stage that owns and drives the `s` select of the mux, so the mux never sees an out-of-range select.

## Interface
- `N`, default 9: words per frame; select width is `$clog2(N)`.
- `W`, default 1: word width in bits.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  frame offered.
- `in_ready`  out  1  frame can be accepted this cycle.
- `in_data`  in  N*W  frame; word k is `in_data[k*W+:W]`.
- `in_mask`  in  N  per-word emit enable. Present only with `MUX_SCAN_MASK_EN`.
- `out_valid`  out  1  word presented.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  W  current word, i.e. mux output for `out_sel`.
- `out_sel`  out  $clog2(N)  index of the current word; always < N.
- `out_last`  out  1  current word is the final one of the frame.

## Operation
- Two states:
  - IDLE: no frame is held.
  - SCAN: a frame is held and `out_valid=1`.
- Registers:
  - `frame_q` (N*W).
  - `sel_q`.
  - `mask_q` (mask build only).
  - `state`.
- `in_ready = (state==IDLE) || (out_valid && out_ready && out_last)`. This is combinational from `out_ready` and allows back-to-back frames.
- Frame accept (`in_valid && in_ready`):
  - Latch `in_data` into `frame_q`.
  - Set `sel_q` to the first emitted index: 0, or the lowest set mask bit in the mask build.
  - Go to SCAN.
- Beat accept in SCAN (`out_valid && out_ready`):
  - When not last: advance `sel_q` to the next emitted index.
  - When last and no new frame is accepted in the same cycle: go to IDLE.
  - When last and a new frame is accepted in the same cycle: stay in SCAN with the new frame.
- Stall (`out_valid && !out_ready`): `out_data`, `out_sel` and `out_last` hold stable.
- `out_data` is driven combinationally by the mux from `frame_q` and `sel_q`. `out_sel = sel_q`.
- Without the mask, `out_last = (sel_q == N-1)`. The select counter wraps from N-1 to 0 only through a new frame load; values N..2^$clog2(N)-1 are never produced.
- Reset:
  - Outputs: `out_valid=0`, `out_last=0`, `out_sel=0`; `in_ready=1` from the first cycle after reset.
  - State: IDLE; `frame_q` is cleared to 0.
  - Reset asserted mid-frame drops the frame silently. `rst` has priority over any simultaneous handshake.

## Timing
- Latency: a frame accepted in cycle t presents its first word at t+1.
- Throughput: one word per cycle while `out_ready=1`.
- Back-to-back frames: with continuous `out_ready`, a frame of N words occupies exactly N cycles with zero bubbles between frames.
- IDLE: `out_valid=0`; `out_data` is don't-care and `out_last=0`.

## Configuration
- Macro: `MUX_SCAN_MASK_EN`.
- Defined:
  - The `in_mask` port exists and is latched with the frame.
  - The sequencer visits only the indices whose mask bit is 1, in ascending order.
  - `out_last` is 1 when no set bit lies above `sel_q`.
  - An all-zero mask is accepted and discarded: the block stays in or returns to IDLE and emits no beat.
- Undefined:
  - No `in_mask` port.
  - Every index 0..N-1 is emitted.

## Structure
- Shared package `mux_scan_pkg`, containing:
  - The state enum {IDLE, SCAN}.
  - The `SEL_W = $clog2(N)` function or constant.
  - A `next_set_idx` function for the mask build.
- One sub-module: the select-to-word path instantiates `mux_if_bal_9_1` with N and W passed through. No other hierarchy.

## Test plan
- Single frame: reset, then in_data words 0..8 = 1,0,1,1,0,0,1,0,1 with W=1 and `out_ready` held high. Required: `out_valid` rises one cycle after accept; `out_sel` reads 0..8; `out_data` follows the frame; `out_last` only at sel 8; `in_ready` high at sel 8.
- Back-to-back: two frames offered continuously with `out_ready=1`. Required: 18 consecutive valid beats with no bubble; the second frame's sel 0 immediately follows the first frame's sel 8.
- Backpressure: `out_ready` low for 3 cycles at sel 4. Required: `out_sel`, `out_data` and `out_last` stable; `in_ready=0`; the next beat is sel 5.
- Reset mid-frame: assert `rst` at sel 5. Required: the next cycle has `out_valid=0`, `out_sel=0` and `in_ready=1`; a new frame afterwards starts at sel 0.
- Mask build (`MUX_SCAN_MASK_EN`):
  - mask 9'b100010010 emits sel 1, 4, 8, with `out_last` on sel 8.
  - An all-zero mask produces no beat and `in_ready` remains 1.
